fifo_rd_pack32: RTL and testbench



---
 rtl/fifo_rd_pack32.sv | 134 +++++++++++++
 tb/tb_fifo_rd_pack32.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_pack32.sv
// Read-side consumer of the dual-clock FIFO: pops DSIZE-bit words, packs word
// pairs into 2*DSIZE-bit beats and presents them through a 2-entry valid/ready queue.
module fifo_rd_pack32 #(
  parameter int DSIZE = 16,
  parameter int CNTW  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty,
  input  logic [DSIZE-1:0]     rdata,
  output logic                 rinc,
  input  logic                 flush,
  output logic [2*DSIZE-1:0]   out_data,
  output logic [1:0]           out_keep,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      beat_cnt,
  output logic                 busy
);

  logic [DSIZE-1:0]   r_acc;
  logic               r_acc_v;
  logic [2*DSIZE-1:0] r_q_data [2];
  logic [1:0]         r_q_keep [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_q_count;
  logic               r_flush_pend;
  logic [CNTW-1:0]    r_beat_cnt;

  logic               w_q_full;
  logic               w_q_nempty;
  logic               w_pop;
  logic               w_deq;
  logic               w_enq_pair;
  logic               w_enq_flush;
  logic               w_enq;
  logic [2*DSIZE-1:0] w_enq_data;
  logic [1:0]         w_enq_keep;

  // Pop decision uses registered state only, so out_ready never reaches rinc.
  assign w_q_full    = (r_q_count == 2'd2);
  assign w_q_nempty  = (r_q_count != 2'd0);
  assign w_pop       = !rempty && !r_flush_pend && !(r_acc_v && w_q_full);
  assign w_deq       = w_q_nempty && out_ready;
  assign w_enq_pair  = w_pop && r_acc_v;
  assign w_enq_flush = r_flush_pend && r_acc_v && !w_q_full;
  assign w_enq       = w_enq_pair || w_enq_flush;

  // Select the beat being enqueued: completed pair or half-filled flush beat.
  always_comb begin
    w_enq_data = {rdata, r_acc};
    w_enq_keep = 2'b11;
    if (w_enq_flush) begin
      w_enq_data = {{DSIZE{1'b0}}, r_acc};
      w_enq_keep = 2'b01;
    end else begin
      w_enq_data = {rdata, r_acc};
      w_enq_keep = 2'b11;
    end
  end

  // Holds the first word of a pair until its partner is popped or a flush drains it.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_acc   <= {DSIZE{1'b0}};
      r_acc_v <= 1'b0;
    end else if (w_pop) begin
      if (!r_acc_v) begin
        r_acc   <= rdata;
        r_acc_v <= 1'b1;
      end else begin
        r_acc_v <= 1'b0;
      end
    end else if (w_enq_flush) begin
      r_acc_v <= 1'b0;
    end
  end

  // A new pulse always wins over clearing; pending flush waits while the queue is full.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if (r_flush_pend && (!r_acc_v || w_enq_flush)) begin
      r_flush_pend <= 1'b0;
    end
  end

  // Two-entry in-order output queue.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_q_data[i] <= {(2*DSIZE){1'b0}};
        r_q_keep[i] <= 2'b00;
      end
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_q_count <= 2'd0;
    end else begin
      if (w_enq) begin
        r_q_data[r_wr_ptr] <= w_enq_data;
        r_q_keep[r_wr_ptr] <= w_enq_keep;
        r_wr_ptr           <= !r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_q_count <= r_q_count + 2'd1;
        2'b01:   r_q_count <= r_q_count - 2'd1;
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  // Accepted-beat counter, wraps naturally.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_beat_cnt <= {CNTW{1'b0}};
    end else if (w_deq) begin
      r_beat_cnt <= r_beat_cnt + CNTW'(1);
    end
  end

  assign rinc      = w_pop;
  assign out_valid = w_q_nempty;
  assign out_data  = r_q_data[r_rd_ptr];
  assign out_keep  = r_q_keep[r_rd_ptr];
  assign beat_cnt  = r_beat_cnt;
  assign busy      = r_acc_v || w_q_nempty || r_flush_pend;

endmodule

// File: tb/tb_fifo_rd_pack32.sv
// Directed bench for fifo_rd_pack32: zero-latency FIFO model on the read side,
// expected beats queued as words are popped and compared on each accepted beat.
module tb_fifo_rd_pack32;

  localparam int DSIZE = 16;
  localparam int CNTW  = 4;

  logic               rclk = 1'b0;
  logic               rrst_n;
  logic               rempty;
  logic [DSIZE-1:0]   rdata;
  logic               rinc;
  logic               flush;
  logic [2*DSIZE-1:0] out_data;
  logic [1:0]         out_keep;
  logic               out_valid;
  logic               out_ready;
  logic [CNTW-1:0]    beat_cnt;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [DSIZE-1:0]       fifo [$];
  logic [2*DSIZE+1:0]     sb   [$];
  logic [DSIZE-1:0]       m_acc;
  bit                     m_acc_v;

  fifo_rd_pack32 #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic update_fifo_if();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? 16'h0000 : fifo[0];
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo.push_back(w);
    update_fifo_if();
  endtask

  // One clock: sample before the edge, then advance FIFO and expectation model.
  task automatic tick();
    bit p, f;
    logic [2*DSIZE+1:0] e;
    logic [DSIZE-1:0] w;
    #1;
    p = rinc;
    f = flush;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("beat_data", 64'(out_data), 64'(e[2*DSIZE-1:0]));
        check("beat_keep", 64'(out_keep), 64'(e[2*DSIZE+1:2*DSIZE]));
      end
    end
    @(posedge rclk);
    #1;
    if (p) begin
      if (fifo.size() == 0) begin
        check("pop_while_empty", 64'd1, 64'd0);
      end else begin
        w = fifo.pop_front();
        pops++;
        if (m_acc_v) begin
          sb.push_back({2'b11, w, m_acc});
          m_acc_v = 1'b0;
        end else begin
          m_acc   = w;
          m_acc_v = 1'b1;
        end
      end
    end
    if (f && m_acc_v) begin
      sb.push_back({2'b01, 16'h0000, m_acc});
      m_acc_v = 1'b0;
    end
    update_fifo_if();
  endtask

  task automatic run_idle(input int max, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (fifo.size() == 0 && sb.size() == 0 && !busy) done = 1'b1;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_pops(input int n, input int max, input string tag);
    for (int i = 0; i < max && pops < n; i++) tick();
    check(tag, 64'(pops), 64'(n));
  endtask

  task automatic clear_model();
    fifo.delete();
    sb.delete();
    m_acc_v   = 1'b0;
    m_acc     = 16'h0000;
    pops      = 0;
    flush     = 1'b0;
    out_ready = 1'b0;
    update_fifo_if();
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    clear_model();
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clear_model();
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_keep",  64'(out_keep),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_beat_cnt",  64'(beat_cnt),  64'd0);
    check("rst_rinc",      64'(rinc),      64'd0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Four words, two full beats.
    out_ready = 1'b1;
    push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
    run_idle(20, "t1_idle");
    check("t1_pops", 64'(pops), 64'd4);
    check("t1_beat_cnt", 64'(beat_cnt), 64'd2);

    // Odd word count, flush emits the leftover as a partial beat.
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(16'hA000 + 16'(i));
    wait_pops(5, 20, "t2_pops");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_idle(20, "t2_idle");
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_beat_cnt", 64'(beat_cnt), 64'd3);

    // Backpressure: queue fills, acc holds the fifth word, pops stop.
    apply_reset();
    for (int i = 1; i <= 6; i++) push_word(16'hB000 + 16'(i));
    for (int i = 0; i < 10; i++) tick();
    check("t3_pops", 64'(pops), 64'd5);
    check("t3_rinc_stall", 64'(rinc), 64'd0);
    check("t3_rempty", 64'(rempty), 64'd0);
    check("t3_head", 64'(out_data), 64'h0000_0000_B002_B001);
    for (int i = 0; i < 3; i++) tick();
    check("t3_head_stable", 64'(out_data), 64'h0000_0000_B002_B001);
    check("t3_keep", 64'(out_keep), 64'd3);
    check("t3_pops_hold", 64'(pops), 64'd5);
    out_ready = 1'b1;
    run_idle(20, "t3_idle");
    check("t3_pops_all", 64'(pops), 64'd6);
    check("t3_beat_cnt", 64'(beat_cnt), 64'd3);

    // Flush with nothing pending: no beat, pend clears after one cycle.
    apply_reset();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_word(16'hC001); push_word(16'hC002);
    #1;
    check("t4_rinc_blocked", 64'(rinc), 64'd0);
    check("t4_busy_pend", 64'(busy), 64'd1);
    tick();
    check("t4_rinc_resume", 64'(rinc), 64'd1);
    check("t4_no_beat", 64'(out_valid), 64'd0);
    run_idle(20, "t4_idle");
    check("t4_beat_cnt", 64'(beat_cnt), 64'd1);

    // 17 full beats on a 4-bit counter wrap to 1.
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) push_word(16'hD000 + 16'(i));
    run_idle(120, "t5_idle");
    check("t5_beat_cnt_wrap", 64'(beat_cnt), 64'd1);

    // Asynchronous reset with a full queue and a pending word.
    apply_reset();
    for (int i = 1; i <= 6; i++) push_word(16'hE000 + 16'(i));
    for (int i = 0; i < 10; i++) tick();
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    check("t6_pre_busy", 64'(busy), 64'd1);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    apply_reset();
    out_ready = 1'b1;
    push_word(16'h5555); push_word(16'h6666);
    sb.push_back({2'b11, 32'h6666_5555});
    m_acc_v = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        #1;
        if (out_valid) begin
          seen = 1'b1;
          check("t6_new_beat", 64'(out_data), 64'h0000_0000_6666_5555);
        end else begin
          @(posedge rclk);
          #1;
          if (rinc === 1'b0 && fifo.size() != 0) begin
          end
          if (fifo.size() != 0 && pops < 2) begin
            void'(fifo.pop_front());
            pops++;
            update_fifo_if();
          end
        end
      end
      check("t6_beat_seen", 64'(seen), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
